id_issue_queue: RTL

- Parametrised decoupling buffer between the decode stage and execute in the br32 pipeline. It replaces the single-entry decode/execute register.
- Holds up to DEPTH decoded instructions, each carrying pc, nextpc, decoded bundle, operands, condition and branch info.
- Uses a valid/ready handshake on both sides. Flushes on redirect and presents a bubble to execute when empty.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/id_queue_pkg.sv | 19 +
 rtl/id_queue_ptr.sv | 51 +++++
 rtl/id_issue_queue.sv | 98 +++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Decoded-instruction bundle produced by the br32 decode stage.
package decoder_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } decoded_t;

endpackage

// File: rtl/id_queue_pkg.sv
// Shared types and defaults for the decode/execute issue queue.
package id_queue_pkg;
  import decoder_pkg::*;

  localparam int XLEN = 32;
  localparam int ID_Q_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextpc;
    decoded_t        dec;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            cond_true;
    logic            branch;
    logic [XLEN-1:0] branch_dest;
  } id_entry_t;

endpackage

// File: rtl/id_queue_ptr.sv
// Head/tail/occupancy bookkeeping for the issue queue; flush and reset clear all state.
module id_queue_ptr
  import id_queue_pkg::*;
#(
  parameter int DEPTH = ID_Q_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       enq,
  input  logic                       deq,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_en
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A flush cycle swallows both handshakes.
  assign wr_en = enq && !full && !flush;
  assign rd_en = deq && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + PW'(1);
      if (rd_en) head <= head + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// Decode-to-execute issue queue: circular buffer with valid/ready on both sides.
// Optional ID_ISSUE_QUEUE_BYPASS_EN forwards decode straight to execute when empty.
module id_issue_queue
  import id_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEC_W = 64,
  parameter int DEPTH = ID_Q_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_nextpc,
  input  logic [DEC_W-1:0]           in_dec,
  input  logic [XLEN-1:0]            in_op1,
  input  logic [XLEN-1:0]            in_op2,
  input  logic                       in_cond_true,
  input  logic                       in_branch,
  input  logic [XLEN-1:0]            in_branch_dest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_nextpc,
  output logic [DEC_W-1:0]           out_dec,
  output logic [XLEN-1:0]            out_op1,
  output logic [XLEN-1:0]            out_op2,
  output logic                       out_cond_true,
  output logic                       out_branch,
  output logic [XLEN-1:0]            out_branch_dest,
  output logic                       out_bubble,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW      = $clog2(DEPTH);
  localparam int ENTRY_W = 5*XLEN + DEC_W + 2;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] sel_data;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               enq;
  logic               use_byp;

  assign wr_data = {in_pc, in_nextpc, in_dec, in_op1, in_op2,
                    in_cond_true, in_branch, in_branch_dest};

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  // An instruction taken by execute straight from decode is never stored.
  assign use_byp = empty && in_valid && !flush;
  assign enq     = in_valid && !(use_byp && out_ready);
`else
  assign use_byp = 1'b0;
  assign enq     = in_valid;
`endif

  id_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .enq   (enq),
    .deq   (out_ready),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty),
    .wr_en (wr_en)
  );

`ifndef SYNTHESIS
  // Zeroed under reset in simulation so out_* is never X while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '{default: '0};
    else if (wr_en) mem[tail] <= wr_data;
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end
`endif

  assign sel_data = use_byp ? wr_data : mem[head];

  assign {out_pc, out_nextpc, out_dec, out_op1, out_op2,
          out_cond_true, out_branch, out_branch_dest} = sel_data;

  assign in_ready   = !full;
  assign out_valid  = !empty || use_byp;
  assign out_bubble = !out_valid;

endmodule
